// File: rtl/instruction_type_decoder_stage.sv
// ---------------------------------------------------------------------------
// instruction_type_decoder_stage
//
// Front end of the decode stage, sitting just upstream of control_decoder.
// Fetched RV32I instruction words arrive over a valid/ready handshake. The
// 7-bit opcode of each word is decoded into nine one-hot instruction-type
// flags, plus an illegal flag for opcodes that match none of them. The
// decoded flags, the instruction word and its PC are held together in a
// 2-entry skid buffer that acts as the IF/ID pipeline register. The buffer
// supports a downstream stall (out_ready low) and a flush on redirect. A
// saturating counter records how many illegal opcodes have been accepted.
//
// Ports
//   clk              rising-edge clock for all state
//   rst              synchronous, active-high reset
//   flush            discard every buffered entry (branch/jump redirect)
//   in_valid         fetch is presenting an instruction
//   in_ready         this stage can take an instruction this cycle
//   in_instruction   fetched instruction word (XLEN bits)
//   in_pc            PC of the fetched instruction (XLEN bits)
//   out_valid        a decoded entry is available at the head
//   out_ready        execute accepts the head entry; low means stall
//   out_instruction  instruction word of the head entry
//   out_pc           PC of the head entry
//   r_type .. uj_type  one-hot instruction-type flags of the head entry
//   illegal          head entry opcode matches none of the nine types
//   illegal_count    saturating count of accepted illegal instructions
// ---------------------------------------------------------------------------
module instruction_type_decoder_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instruction,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instruction,
  output logic [XLEN-1:0]  out_pc,
  output logic             r_type,
  output logic             i_type_lw,
  output logic             i_type_addi,
  output logic             i_type_jalr,
  output logic             s_type,
  output logic             sb_type,
  output logic             u_type_auipc,
  output logic             u_type_lui,
  output logic             uj_type,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bit order of the decoded type vector, MSB first:
  // r, lw, addi, jalr, s, sb, auipc, lui, uj, illegal
  logic [9:0]      dec_type;

  logic            main_valid;
  logic [XLEN-1:0] main_instruction;
  logic [XLEN-1:0] main_pc;
  logic [9:0]      main_type;

  logic            skid_valid;
  logic [XLEN-1:0] skid_instruction;
  logic [XLEN-1:0] skid_pc;
  logic [9:0]      skid_type;

  logic            accept;
  logic            pop;

  // The skid register is the only thing that can block fetch, so in_ready
  // comes straight from a flop. This keeps out_ready off any combinational
  // path back to in_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  // Opcode decode of the incoming word. The result is stored with the entry,
  // so the flags at the output always belong to the head instruction.
  always_comb begin
    dec_type = 10'b00_0000_0001;
    case (in_instruction[6:0])
      7'b0110011: dec_type = 10'b10_0000_0000;
      7'b0000011: dec_type = 10'b01_0000_0000;
      7'b0010011: dec_type = 10'b00_1000_0000;
      7'b1100111: dec_type = 10'b00_0100_0000;
      7'b0100011: dec_type = 10'b00_0010_0000;
      7'b1100011: dec_type = 10'b00_0001_0000;
      7'b0010111: dec_type = 10'b00_0000_1000;
      7'b0110111: dec_type = 10'b00_0000_0100;
      7'b1101111: dec_type = 10'b00_0000_0010;
      default:    dec_type = 10'b00_0000_0001;
    endcase
  end

  // Main/skid buffer control. The main register is always the head of the
  // queue. A new entry only lands in the skid register when main is full
  // and is not being popped; on the next pop the skid entry moves forward.
  // An accept can never coincide with a full skid because in_ready is low
  // then, so the pop-with-skid branch needs no accept handling. A flush
  // just clears the valid bits and leaves the data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid       <= 1'b0;
      main_instruction <= '0;
      main_pc          <= '0;
      main_type        <= '0;
      skid_valid       <= 1'b0;
      skid_instruction <= '0;
      skid_pc          <= '0;
      skid_type        <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        main_instruction <= skid_instruction;
        main_pc          <= skid_pc;
        main_type        <= skid_type;
        skid_valid       <= 1'b0;
      end else if (accept) begin
        main_instruction <= in_instruction;
        main_pc          <= in_pc;
        main_type        <= dec_type;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_valid       <= 1'b1;
        skid_instruction <= in_instruction;
        skid_pc          <= in_pc;
        skid_type        <= dec_type;
      end else begin
        main_valid       <= 1'b1;
        main_instruction <= in_instruction;
        main_pc          <= in_pc;
        main_type        <= dec_type;
      end
    end
  end

  // Illegal opcodes are counted at the moment they are accepted. This
  // includes words that a later (or same-cycle) flush throws away. The
  // counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (accept && dec_type[0] && (illegal_count != CNT_MAX)) begin
      illegal_count <= illegal_count + CNT_ONE;
    end
  end

  // The head entry drives the outputs. The type flags are gated by
  // out_valid, so all ten read zero while the buffer is empty.
  assign out_valid       = main_valid;
  assign out_instruction = main_instruction;
  assign out_pc          = main_pc;
  assign {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type,
          u_type_auipc, u_type_lui, uj_type, illegal} =
         main_valid ? main_type : 10'b0;

endmodule

// File: tb/tb_instruction_type_decoder_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_type_decoder_stage
//
// Self-checking bench for instruction_type_decoder_stage. A reference model
// holds the buffered entries as a plain queue with a capacity of two, plus an
// integer illegal count. Expected type flags come from a table lookup of the
// nine legal opcodes. Inputs change on the falling edge. Outputs are compared
// on the falling edge, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_type_decoder_stage;

  typedef struct {
    logic [31:0] instruction;
    logic [31:0] pc;
  } entry_t;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Legal opcodes in flag order: r, lw, addi, jalr, s, sb, auipc, lui, uj
  localparam logic [6:0] OPCODES [9] = '{7'b0110011, 7'b0000011, 7'b0010011,
                                          7'b1100111, 7'b0100011, 7'b1100011,
                                          7'b0010111, 7'b0110111, 7'b1101111};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type;
  logic        u_type_auipc, u_type_lui, uj_type, illegal;
  logic [CNT_W-1:0] illegal_count;

  int     checks = 0;
  int     failures = 0;
  entry_t model_q[$];
  int     model_count = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  instruction_type_decoder_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .r_type          (r_type),
    .i_type_lw       (i_type_lw),
    .i_type_addi     (i_type_addi),
    .i_type_jalr     (i_type_jalr),
    .s_type          (s_type),
    .sb_type         (sb_type),
    .u_type_auipc    (u_type_auipc),
    .u_type_lui      (u_type_lui),
    .uj_type         (uj_type),
    .illegal         (illegal),
    .illegal_count   (illegal_count)
  );

  always #5 clk = ~clk;

  // Flag vector that the model expects for a word, MSB = r_type, LSB = illegal
  function automatic logic [9:0] expectedFlags(input logic [31:0] word);
    for (int i = 0; i < 9; i++) begin
      if (word[6:0] == OPCODES[i]) return 10'(1) << (9 - i);
    end
    return 10'b1;
  endfunction

  function automatic logic isIllegal(input logic [31:0] word);
    return expectedFlags(word) == 10'b1;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output with the model's current queue state
  task automatic compareState();
    logic [9:0] flags;
    flags = {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type,
             u_type_auipc, u_type_lui, uj_type, illegal};
    checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    checkOutput("illegal_count", 64'(illegal_count), 64'(model_count));
    checkOutput("flags_onehot0", 64'($onehot0(flags)), 64'(1));
    if (model_q.size() > 0) begin
      checkOutput("flags", 64'(flags), 64'(expectedFlags(model_q[0].instruction)));
      checkOutput("out_instruction", 64'(out_instruction), 64'(model_q[0].instruction));
      checkOutput("out_pc", 64'(out_pc), 64'(model_q[0].pc));
    end else begin
      checkOutput("flags_idle", 64'(flags), 64'(0));
    end
  endtask

  // Drive one cycle of inputs, check the outputs, then advance the model and
  // the clock together
  task automatic applyStimulus(input logic iv, input logic [31:0] word,
                               input logic ordy, input logic fl);
    logic   acc;
    logic   pop;
    entry_t e;
    in_valid       = iv;
    in_instruction = word;
    in_pc          = pc_next;
    out_ready      = ordy;
    flush          = fl;
    compareState();
    acc = iv && (model_q.size() < 2);
    pop = ordy && (model_q.size() > 0);
    if (acc && isIllegal(word) && model_count < CNT_MAX) model_count++;
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc) begin
        e.instruction = word;
        e.pc          = pc_next;
        model_q.push_back(e);
      end
    end
    if (acc) pc_next = pc_next + 32'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Synchronous reset followed by explicit checks of the reset values
  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_count = 0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_out_pc", 64'(out_pc), 64'(0));
    checkOutput("rst_out_instruction", 64'(out_instruction), 64'(0));
    checkOutput("rst_illegal_count", 64'(illegal_count), 64'(0));
  endtask

  function automatic logic [31:0] randomWord();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = OPCODES[k];
    return w;
  endfunction

  logic [31:0] legal_words [9] = '{32'h00B50533, 32'h0005A503, 32'h00150513,
                                   32'h000080E7, 32'h00B52023, 32'h00B50463,
                                   32'h00000517, 32'h000005B7, 32'h008000EF};

  initial begin
    @(negedge clk);
    doReset();

    // Stream of all nine legal types, back to back
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, legal_words[i], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Stall: A and B fill main and skid, C is held until out_ready rises
    applyStimulus(1'b1, 32'h00C58633, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0045A683, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h00D60713, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00D60713, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Illegal opcodes
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("illegal_count_two", 64'(illegal_count), 64'(2));

    // Flush with a full buffer and a word on the input
    applyStimulus(1'b1, 32'h00B50533, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0005A503, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00150513, 1'b0, 1'b1);
    // Flush with one entry while an accept happens in the same cycle
    applyStimulus(1'b1, 32'h000005B7, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h008000EF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset with both entries valid
    applyStimulus(1'b1, 32'h00000517, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h000080E7, 1'b0, 1'b0);
    doReset();

    // Saturation of the illegal counter
    for (int i = 0; i < CNT_MAX + 5; i++) applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b0);
    checkOutput("illegal_count_sat", 64'(illegal_count), 64'(CNT_MAX));
    doReset();

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randomWord(),
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
